// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Round-robin front end that shares one 6x6 signed Booth multiplier between
//   two requesters. In IDLE it picks a winner, latches that requester's
//   operands onto mul_x/mul_y and pulses mul_load together with the grant.
//   It then waits MUL_CYCLES cycles, captures mul_product into p_out and
//   returns it with a one-cycle done pulse to the winner.
//
// Ports
//   clk, reset              rising-edge clock, async active-low reset
//   req0/req1               request levels (not queued)
//   a0,b0 / a1,b1           signed operands, sampled only on grant
//   gnt0/gnt1               one-cycle grant pulse (operands latched)
//   done0/done1             one-cycle completion pulse (p_out valid)
//   p_out                   product of the last completed operation
//   busy                    high in every state except IDLE
//   mul_x, mul_y, mul_load  to the multiplier x / y / load pins
//   mul_product             from the multiplier product pin
module booth_mul_arbiter #(
  parameter int MUL_CYCLES = 7  // 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [5:0]  a0,
  input  logic [5:0]  b0,
  input  logic [5:0]  a1,
  input  logic [5:0]  b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [11:0] p_out,
  output logic        busy,
  output logic [5:0]  mul_x,
  output logic [5:0]  mul_y,
  output logic        mul_load,
  input  logic [11:0] mul_product
);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, DONE} state_t;

  localparam logic [3:0] LOAD_CNT = 4'(MUL_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic       last;   // requester served most recently
  logic       owner;  // requester of the operation in flight
  logic       win;

  // Single request wins outright; on a tie the one not served last wins.
  assign win = (req0 & req1) ? ~last : req1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      owner    <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      busy     <= 1'b0;
      mul_load <= 1'b0;
      mul_x    <= '0;
      mul_y    <= '0;
      p_out    <= '0;
    end else begin
      // pulses default low; each is raised for exactly one cycle below
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      mul_load <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state    <= LOAD;
            owner    <= win;
            mul_x    <= win ? a1 : a0;
            mul_y    <= win ? b1 : b0;
            cnt      <= LOAD_CNT;
            gnt0     <= ~win;
            gnt1     <= win;
            mul_load <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: state <= BUSY;
        BUSY: begin
          cnt <= cnt - 4'd1;
          // last BUSY cycle: product is valid now, present it in DONE
          if (cnt == 4'd1) begin
            state <= DONE;
            p_out <= mul_product;
            done0 <= ~owner;
            done1 <= owner;
          end
        end
        DONE: begin
          state <= IDLE;
          last  <= owner;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
